// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU responder for EX.
// Optional DIV_EARLY_TERM_EN: finish at E1 when |dividend| < |divisor|.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {
    DivFree,
    DivByZero,
    DivOn,
    DivEnd
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              take;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] early_rem;
  logic              early;

  // Operand magnitudes; the dividend register shifts out and
  // collects quotient bits in place.
  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[DATA_W-1])
            ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[DATA_W-1])
            ? -opdata2_i : opdata2_i;
    trial   = {rem_q, dvd_q[DATA_W-1]};
    diff    = trial - {1'b0, dsr_q};
    take    = ~diff[DATA_W];
    rem_nxt = take ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_nxt = {dvd_q[DATA_W-2:0], take};
    quo_fix = negq_q ? -quo_nxt : quo_nxt;
    rem_fix = negr_q ? -rem_nxt : rem_nxt;
    early_rem = negr_q ? -dvd_q : dvd_q;
  end

`ifdef DIV_EARLY_TERM_EN
  assign early = (cnt_q == '0) && (dvd_q < dsr_q);
`else
  assign early = 1'b0;
`endif

  // Next-state and datapath update for the divide FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = 1'b0;
        cnt_d    = '0;
        if (start_i && !annul_i) begin
          dvd_d  = op1_mag;
          dsr_d  = op2_mag;
          rem_d  = '0;
          negq_d = signed_div_i &&
                   (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          negr_d = signed_div_i && opdata1_i[DATA_W-1];
          state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else if (early) begin
          result_d = {early_rem, {DATA_W{1'b0}}};
          ready_d  = 1'b1;
          state_d  = DivEnd;
        end else begin
          dvd_d = quo_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Expected {rem, quo} comes from plain SV arithmetic.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic rdy_prev = 1'b0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(bit sg, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  function automatic int lat(bit sg, logic [31:0] a, logic [31:0] b);
`ifdef DIV_EARLY_TERM_EN
    logic [31:0] ma, mb;
`endif
    if (b == 0) return 1;
`ifdef DIV_EARLY_TERM_EN
    ma = (sg && a[31]) ? 32'(0 - a) : a;
    mb = (sg && b[31]) ? 32'(0 - b) : b;
    if (ma < mb) return 1;
`endif
    return 32;
  endfunction

  // Scoreboard monitor: every rising ready_o consumes one expectation.
  always @(negedge clk) begin
    if (rst) begin
      rdy_prev = 1'b0;
    end else begin
      if (ready_o && !rdy_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got %h want none", result_o);
        end else begin
          check("result", result_o, exp_q.pop_front());
        end
      end
      rdy_prev = ready_o;
    end
  end

  // Present a request and return just after the accept edge,
  // scrambling the operand inputs to prove they were latched.
  task automatic issue(bit sg, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = 1'($urandom);
  endtask

  task automatic run_div(bit sg, logic [31:0] a, logic [31:0] b,
                         int hold, bit keep);
    logic [63:0] e;
    int el;
    int n;
    e = model(sg, a, b);
    el = lat(sg, a, b);
    n = 0;
    exp_q.push_back(e);
    issue(sg, a, b);
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ready_o && n < 100);
    check("latency", 64'(n), 64'(el));
    repeat (hold) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, e);
    end
    if (!keep) begin
      start_i = 1'b0;
      @(negedge clk);
      check("drop_ready", 64'(ready_o), 64'd0);
      check("drop_result", result_o, 64'd0);
    end
  endtask

  task automatic quiet(string name, int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit sg;
    int sel;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 5, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_div(1'b0, 32'h1234_5678, 32'd0, 1, 1'b0);
    run_div(1'b1, 32'h1234_5678, 32'd0, 0, 1'b0);

    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    quiet("annul_quiet", 40);
    run_div(1'b0, 32'd6, 32'd3, 0, 1'b0);

    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    quiet("start_annul_quiet", 40);

    issue(1'b0, 32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_e15_ready", 64'(ready_o), 64'd0);
    check("rst_e15_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 2, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd5, 32'd9, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd9, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40));
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(sg, a, b, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
